// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchronised, counter-verified switch debouncer with edge strobes
module input_debouncer #(
  parameter int   STABLE_CYCLES = 16,
  parameter int   CNT_W         = 5,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_async,
  input  logic enable,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    VERIFY = 1'b1
  } state_t;

  // Count value reached on the last differing sample before a change commits.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic             sample;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             commit;
  logic             dout_next;
  logic             rise_next;
  logic             fall_next;
  logic             busy_next;

  assign sample = s2;

  // Two-flop synchroniser for the raw input; runs regardless of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
    end else begin
      s1 <= din_async;
      s2 <= s1;
    end
  end

  // State, counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dout       <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      dout       <= dout_next;
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
      busy       <= busy_next;
    end
  end

  // Next state: start verifying on a differing sample, abort on disable or glitch,
  // commit once the differing level has been seen STABLE_CYCLES times in a row.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (sample != dout)) begin
          state_next = VERIFY;
          cnt_next   = CNT_ONE;
        end
      end
      VERIFY: begin
        if (!enable || (sample == dout)) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output values to register: toggle level and fire the matching strobe on commit.
  always_comb begin
    dout_next = dout;
    rise_next = 1'b0;
    fall_next = 1'b0;
    busy_next = (state_next == VERIFY);
    if (commit) begin
      dout_next = ~dout;
      rise_next = ~dout;
      fall_next = dout;
    end
  end

endmodule
